// File: rtl/seg7_io_ctrl_pkg.sv
// Shared definitions for the 8-digit seven-segment controller: segment glyphs,
// conversion FSM encoding and the nibble-to-glyph lookup.
package seg7_io_ctrl_pkg;

  // Segment order {a,b,c,d,e,f,g,dp}, bit7 = a, active-high; dp is never lit
  localparam logic [7:0] SEG_0     = 8'hFC;
  localparam logic [7:0] SEG_1     = 8'h60;
  localparam logic [7:0] SEG_2     = 8'hDA;
  localparam logic [7:0] SEG_3     = 8'hF2;
  localparam logic [7:0] SEG_4     = 8'h66;
  localparam logic [7:0] SEG_5     = 8'hB6;
  localparam logic [7:0] SEG_6     = 8'hBE;
  localparam logic [7:0] SEG_7     = 8'hE0;
  localparam logic [7:0] SEG_8     = 8'hFE;
  localparam logic [7:0] SEG_9     = 8'hF6;
  localparam logic [7:0] SEG_A     = 8'hEE;
  localparam logic [7:0] SEG_B     = 8'h3E;
  localparam logic [7:0] SEG_C     = 8'h9C;
  localparam logic [7:0] SEG_D     = 8'h7A;
  localparam logic [7:0] SEG_E     = 8'h9E;
  localparam logic [7:0] SEG_F     = 8'h8E;
  localparam logic [7:0] SEG_DASH  = 8'h02;
  localparam logic [7:0] SEG_BLANK = 8'h00;

  localparam int          CONV_CYCLES = 32;
  localparam logic [31:0] DEC_LIMIT   = 32'd100_000_000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_DONE = 2'd2
  } conv_state_e;

  function automatic logic [7:0] seg_code(input logic [3:0] d);
    case (d)
      4'h0: return SEG_0;
      4'h1: return SEG_1;
      4'h2: return SEG_2;
      4'h3: return SEG_3;
      4'h4: return SEG_4;
      4'h5: return SEG_5;
      4'h6: return SEG_6;
      4'h7: return SEG_7;
      4'h8: return SEG_8;
      4'h9: return SEG_9;
      4'hA: return SEG_A;
      4'hB: return SEG_B;
      4'hC: return SEG_C;
      4'hD: return SEG_D;
      4'hE: return SEG_E;
      default: return SEG_F;
    endcase
  endfunction

endpackage

// File: rtl/seg7_bin2bcd.sv
// Iterative shift-add-3 binary-to-BCD converter: one bit per cycle, 32 cycles,
// then a one-cycle DONE with the low eight BCD digits and an overflow flag.
module seg7_bin2bcd
  import seg7_io_ctrl_pkg::*;
(
  input  logic        clock,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] value,
  output logic        busy,
  output logic        done,
  output logic [31:0] bcd,
  output logic        overflow
);

  conv_state_e state_q, state_d;
  logic [4:0]  cnt_q;
  logic [31:0] bin_q;
  logic [31:0] bcd_q;
  logic [31:0] bcd_adj;
  logic        ovf_q;

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 8; i++)
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
  end

  // A fresh start always wins, so a new decimal write restarts from count 0
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_CONV: if (cnt_q == 5'(CONV_CYCLES - 1)) state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
    if (abort) state_d = ST_IDLE;
    if (start) state_d = ST_CONV;
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bin_q   <= '0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start) begin
        cnt_q <= '0;
        bin_q <= value;
        bcd_q <= '0;
        ovf_q <= (value >= DEC_LIMIT);
      end else if (state_q == ST_CONV) begin
        // Digits above the eighth fall off the top; overflow covers that range
        cnt_q <= cnt_q + 5'd1;
        bcd_q <= {bcd_adj[30:0], bin_q[31]};
        bin_q <= {bin_q[30:0], 1'b0};
      end
    end
  end

  assign busy     = (state_q == ST_CONV);
  assign done     = (state_q == ST_DONE);
  assign bcd      = bcd_q;
  assign overflow = ovf_q;

endmodule

// File: rtl/seg7_io_ctrl.sv
// Memory-mapped 8-digit seven-segment controller, hex or decimal display with
// multiplexed scan. Optional leading-zero blanking under SEG7_LZB_EN.
module seg7_io_ctrl
  import seg7_io_ctrl_pkg::*;
#(
  parameter int DIV_WIDTH = 17
) (
  input  logic        clock,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic [31:0] wr_data,
  input  logic        dec_mode,
  output logic [3:0]  ena_r,
  output logic [3:0]  ena_l,
  output logic [7:0]  led_r,
  output logic [7:0]  led_l,
  output logic        busy
);

  logic [31:0]          val_q;
  logic                 mode_q;
  logic                 wr_q;
  logic [7:0][3:0]      dig_q;
  logic                 dash_q;
  logic [DIV_WIDTH-1:0] div_q;
  logic [1:0]           idx_q;
  logic [2:0]           idx_l;
  logic [7:0]           blank;
  logic [7:0]           glyph_r, glyph_l;
  logic                 cv_done, cv_ovf;
  logic [31:0]          cv_bcd;

  seg7_bin2bcd u_bin2bcd (
    .clock    (clock),
    .rst_n    (rst_n),
    .start    (wr_en & dec_mode),
    .abort    (wr_en & ~dec_mode),
    .value    (wr_data),
    .busy     (busy),
    .done     (cv_done),
    .bcd      (cv_bcd),
    .overflow (cv_ovf)
  );

  // A write landing on DONE supersedes the finished result
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      val_q  <= '0;
      mode_q <= 1'b0;
      wr_q   <= 1'b0;
      dig_q  <= '0;
      dash_q <= 1'b0;
    end else begin
      wr_q <= wr_en;
      if (wr_en) begin
        val_q  <= wr_data;
        mode_q <= dec_mode;
      end
      if (wr_q && !mode_q) begin
        dig_q  <= val_q;
        dash_q <= 1'b0;
      end else if (cv_done && !wr_en) begin
        dig_q  <= cv_bcd;
        dash_q <= cv_ovf;
      end
    end
  end

  always_comb begin
    blank = '0;
`ifdef SEG7_LZB_EN
    begin
      logic lead;
      lead = !dash_q;
      for (int k = 7; k >= 1; k--) begin
        lead     = lead && (dig_q[k] == 4'd0);
        blank[k] = lead;
      end
    end
`endif
  end

  always_comb begin
    idx_l   = {1'b1, idx_q};
    glyph_r = blank[idx_q] ? SEG_BLANK : seg_code(dig_q[idx_q]);
    glyph_l = blank[idx_l] ? SEG_BLANK : seg_code(dig_q[idx_l]);
    if (dash_q) begin
      glyph_r = SEG_DASH;
      glyph_l = SEG_DASH;
    end
  end

  // Outputs refresh at each divider wrap showing the current index, then step it
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
      idx_q <= '0;
      ena_r <= '0;
      ena_l <= '0;
      led_r <= '0;
      led_l <= '0;
    end else begin
      div_q <= div_q + 1'b1;
      if (&div_q) begin
        idx_q <= idx_q + 2'd1;
        ena_r <= 4'b0001 << idx_q;
        ena_l <= 4'b0001 << idx_q;
        led_r <= glyph_r;
        led_l <= glyph_l;
      end
    end
  end

endmodule

// File: tb/tb_seg7_io_ctrl.sv
// Scoreboard bench for seg7_io_ctrl: expected display frames are queued per write
// and a monitor compares each full four-position scan against the queue head.
module tb_seg7_io_ctrl;

  localparam int DW = 4;
  localparam logic [127:0] GLYPHS = {
    8'h8E, 8'h9E, 8'h7A, 8'h9C, 8'h3E, 8'hEE, 8'hF6, 8'hFE,
    8'hE0, 8'hBE, 8'hB6, 8'h66, 8'hF2, 8'hDA, 8'h60, 8'hFC};

  typedef logic [7:0][7:0] frame_t;

  logic        clock = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [31:0] wr_data = '0;
  logic        dec_mode = 1'b0;
  logic [3:0]  ena_r, ena_l;
  logic [7:0]  led_r, led_l;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;
  frame_t exp_q[$];

  seg7_io_ctrl #(.DIV_WIDTH(DW)) dut (
    .clock(clock), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data),
    .dec_mode(dec_mode), .ena_r(ena_r), .ena_l(ena_l), .led_r(led_r),
    .led_l(led_l), .busy(busy)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: digits from plain arithmetic on the written value
  function automatic frame_t model(input logic [31:0] v, input logic dec);
    frame_t f;
    int d[8];
    longint unsigned p = 1;
    int top = 0;
    if (dec && v >= 32'd100_000_000) begin
      for (int k = 0; k < 8; k++) f[k] = 8'h02;
      return f;
    end
    for (int k = 0; k < 8; k++) begin
      d[k] = dec ? int'((longint'(v) / p) % 10) : int'((v >> (4 * k)) & 32'hF);
      p = p * 10;
      if (d[k] != 0) top = k;
      f[k] = GLYPHS[d[k] * 8 +: 8];
    end
`ifdef SEG7_LZB_EN
    for (int k = 1; k < 8; k++) if (k > top) f[k] = 8'h00;
`endif
    return f;
  endfunction

  task automatic write_val(input logic [31:0] v, input logic m);
    @(negedge clock);
    wr_en = 1'b1; wr_data = v; dec_mode = m;
    @(negedge clock);
    wr_en = 1'b0;
  endtask

  task automatic wait_drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 2000) begin
      @(negedge clock);
      t++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL frame_timeout: %0d frames pending, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic settle_push(input logic [31:0] v, input logic m);
    int n = 0;
    if (m) begin
      while (busy && n < 100) begin
        n++;
        @(negedge clock);
      end
      chk("busy_len", 64'(n), 64'd32);
    end
    repeat (2) @(negedge clock);
    exp_q.push_back(model(v, m));
    wait_drain();
  endtask

  task automatic do_write(input logic [31:0] v, input logic m);
    write_val(v, m);
    settle_push(v, m);
  endtask

  // Monitor: a frame is one scan starting at the first enable after a push
  initial begin
    logic [3:0] prev = '0;
    int pos = -1;
    forever begin
      @(negedge clock);
      if (!rst_n) begin
        prev = '0;
        pos  = -1;
      end else if (ena_r != prev) begin
        if (pos < 0 && exp_q.size() != 0 && ena_r == 4'b0001) pos = 0;
        if (pos >= 0) begin
          chk("ena_r", 64'(ena_r), 64'(4'b0001 << pos));
          chk("ena_l", 64'(ena_l), 64'(4'b0001 << pos));
          chk($sformatf("led_r[%0d]", pos), 64'(led_r), 64'(exp_q[0][pos]));
          chk($sformatf("led_l[%0d]", pos + 4), 64'(led_l), 64'(exp_q[0][pos + 4]));
          pos++;
          if (pos == 4) begin
            void'(exp_q.pop_front());
            pos = -1;
          end
        end
        prev = ena_r;
      end
    end
  end

  initial begin
    logic [31:0] v;
    logic        m;
    int          sel;

    repeat (3) @(negedge clock);
    chk("rst_ena_r", 64'(ena_r), 64'd0);
    chk("rst_ena_l", 64'(ena_l), 64'd0);
    chk("rst_led_r", 64'(led_r), 64'd0);
    chk("rst_led_l", 64'(led_l), 64'd0);
    chk("rst_busy",  64'(busy),  64'd0);
    rst_n = 1'b1;
    exp_q.push_back(model(32'd0, 1'b0));
    wait_drain();

    do_write(32'h0000_00A5, 1'b0);
    do_write(32'd12345678, 1'b1);
    do_write(32'd100000000, 1'b1);
    do_write(32'd99999999, 1'b1);

    // Hex write during conversion aborts it
    write_val(32'd99, 1'b1);
    repeat (9) @(negedge clock);
    chk("busy_before_abort", 64'(busy), 64'd1);
    write_val(32'h1234, 1'b0);
    chk("busy_after_abort", 64'(busy), 64'd0);
    repeat (40) @(negedge clock);
    chk("busy_stays_low", 64'(busy), 64'd0);
    exp_q.push_back(model(32'h1234, 1'b0));
    wait_drain();

    // Decimal write during conversion restarts the count
    write_val(32'd500, 1'b1);
    repeat (6) @(negedge clock);
    write_val(32'd4321, 1'b1);
    settle_push(32'd4321, 1'b1);

    do_write(32'h0000_0007, 1'b0);
    do_write(32'd0, 1'b1);

    for (int i = 0; i < 12; i++) begin
      m   = 1'($urandom_range(0, 1));
      sel = $urandom_range(0, 2);
      v   = (sel == 0) ? $urandom :
            (sel == 1) ? 32'($urandom_range(0, 99999999)) : 32'($urandom_range(0, 300));
      do_write(v, m);
    end

    // Asynchronous reset mid-conversion discards it
    write_val(32'd12345678, 1'b1);
    repeat (4) @(negedge clock);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ena_r", 64'(ena_r), 64'd0);
    chk("arst_ena_l", 64'(ena_l), 64'd0);
    chk("arst_led_r", 64'(led_r), 64'd0);
    chk("arst_led_l", 64'(led_l), 64'd0);
    chk("arst_busy",  64'(busy),  64'd0);
    repeat (2) @(negedge clock);
    rst_n = 1'b1;
    @(negedge clock);
    chk("post_rst_busy", 64'(busy), 64'd0);
    repeat (40) @(negedge clock);
    chk("post_rst_busy_late", 64'(busy), 64'd0);
    exp_q.push_back(model(32'd0, 1'b0));
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
